// File: rtl/cpu_div_pkg.sv
// Shared definitions for the divide issue/retire path.
// Contents: operand width, controller state encoding, HI/LO select codes
// used by the decode stage when steering MFHI/MFLO/MTHI/MTLO.
package cpu_div_pkg;

    // Operand/result width; the attached divider is fixed at 32 bits.
    localparam int unsigned XLEN = 32;

    // Controller states.
    typedef enum logic [0:0] {
        DIV_IDLE = 1'b0,
        DIV_RUN  = 1'b1
    } div_state_e;

    // HI/LO select codes shared with decode.
    localparam logic HILO_SEL_LO = 1'b0;
    localparam logic HILO_SEL_HI = 1'b1;

endpackage

// File: rtl/hilo_regs.sv
// HI/LO architectural registers.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   res_we, res_hi/lo     divide result write (both registers together)
//   mt_hi_we, mt_lo_we    MTHI/MTLO write enables
//   mt_wdata              MTHI/MTLO data
//   hi, lo                register contents
// Priority: reset > divide result > MTHI/MTLO.
module hilo_regs
    import cpu_div_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            res_we,
    input  logic [XLEN-1:0] res_hi,
    input  logic [XLEN-1:0] res_lo,
    input  logic            mt_hi_we,
    input  logic            mt_lo_we,
    input  logic [XLEN-1:0] mt_wdata,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    // A divide result owns both registers for the cycle it is written.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (res_we) begin
            hi <= res_hi;
            lo <= res_lo;
        end else begin
            if (mt_hi_we) hi <= mt_wdata;
            if (mt_lo_we) lo <= mt_wdata;
        end
    end

endmodule

// File: rtl/div_issue_ctrl.sv
// Issue/retire controller between EX and the iterative divider.
// Accepts DIV/DIVU, drives the divider's level interface (div, div_signed, x, y),
// captures quotient/remainder into HI/LO on the complete pulse, serves
// MFHI/MFLO/MTHI/MTLO and stalls EX while a divide is in flight.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   req_valid/signed/x/y, req_ready divide request from EX
//   flush                           aborts any in-flight divide
//   mt_hi_we, mt_lo_we, mt_wdata    MTHI/MTLO
//   mf_req                          MFHI/MFLO in EX this cycle
//   hi_rdata, lo_rdata              HI/LO contents
//   stall                           hold EX while busy and EX needs HI/LO or the divider
//   div, div_signed, x, y           to divider
//   s, r, complete                  from divider
// Build option: DIV_ZERO_FAST_EN retires divide-by-zero in one cycle without
// starting the divider (LO = all ones, HI = dividend).
module div_issue_ctrl
    import cpu_div_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    input  logic            req_signed,
    input  logic [XLEN-1:0] req_x,
    input  logic [XLEN-1:0] req_y,
    output logic            req_ready,
    input  logic            flush,
    input  logic            mt_hi_we,
    input  logic            mt_lo_we,
    input  logic [XLEN-1:0] mt_wdata,
    input  logic            mf_req,
    output logic [XLEN-1:0] hi_rdata,
    output logic [XLEN-1:0] lo_rdata,
    output logic            stall,
    output logic            div,
    output logic            div_signed,
    output logic [XLEN-1:0] x,
    output logic [XLEN-1:0] y,
    input  logic [XLEN-1:0] s,
    input  logic [XLEN-1:0] r,
    input  logic            complete
);

    div_state_e      state_q, state_d;
    logic            div_q, div_d;
    logic            sgn_q, sgn_d;
    logic [XLEN-1:0] x_q, x_d;
    logic [XLEN-1:0] y_q, y_d;

    logic            res_we;
    logic [XLEN-1:0] res_hi;
    logic [XLEN-1:0] res_lo;
    logic            busy;

    assign busy = (state_q == DIV_RUN);

    // State and divider-drive registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DIV_IDLE;
            div_q   <= 1'b0;
            sgn_q   <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            sgn_q   <= sgn_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    // Next state, operand capture and result write.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        sgn_d   = sgn_q;
        x_d     = x_q;
        y_d     = y_q;
        res_we  = 1'b0;
        res_hi  = r;
        res_lo  = s;
        case (state_q)
            DIV_IDLE: begin
                if (req_valid && !flush) begin
                    x_d   = req_x;
                    y_d   = req_y;
                    sgn_d = req_signed;
`ifdef DIV_ZERO_FAST_EN
                    // Zero divisor retires here; the divider is never started.
                    if (req_y == '0) begin
                        res_we = 1'b1;
                        res_hi = req_x;
                        res_lo = '1;
                    end else begin
                        div_d   = 1'b1;
                        state_d = DIV_RUN;
                    end
`else
                    div_d   = 1'b1;
                    state_d = DIV_RUN;
`endif
                end
            end
            DIV_RUN: begin
                // Operands stay put: the divider samples x/y sign bits live.
                if (flush) begin
                    div_d   = 1'b0;
                    state_d = DIV_IDLE;
                end else if (complete) begin
                    res_we  = 1'b1;
                    div_d   = 1'b0;
                    state_d = DIV_IDLE;
                end
            end
            default: begin
                div_d   = 1'b0;
                state_d = DIV_IDLE;
            end
        endcase
    end

    // HI/LO storage; MT* only lands while idle (EX is stalled otherwise).
    hilo_regs u_hilo (
        .clk      (clk),
        .reset    (reset),
        .res_we   (res_we),
        .res_hi   (res_hi),
        .res_lo   (res_lo),
        .mt_hi_we (mt_hi_we && !busy),
        .mt_lo_we (mt_lo_we && !busy),
        .mt_wdata (mt_wdata),
        .hi       (hi_rdata),
        .lo       (lo_rdata)
    );

    assign req_ready  = !busy;
    assign stall      = busy && (req_valid || mf_req || mt_hi_we || mt_lo_we);
    assign div        = div_q;
    assign div_signed = sgn_q;
    assign x          = x_q;
    assign y          = y_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a small behavioural divider.
module tb_div_issue_ctrl;

    localparam int unsigned LAT = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_signed;
    logic [31:0] req_x, req_y;
    logic        req_ready;
    logic        flush;
    logic        mt_hi_we, mt_lo_we;
    logic [31:0] mt_wdata;
    logic        mf_req;
    logic [31:0] hi_rdata, lo_rdata;
    logic        stall;
    logic        div, div_signed;
    logic [31:0] x, y;
    logic [31:0] s, r;
    logic        complete;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    div_issue_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_signed (req_signed),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_ready  (req_ready),
        .flush      (flush),
        .mt_hi_we   (mt_hi_we),
        .mt_lo_we   (mt_lo_we),
        .mt_wdata   (mt_wdata),
        .mf_req     (mf_req),
        .hi_rdata   (hi_rdata),
        .lo_rdata   (lo_rdata),
        .stall      (stall),
        .div        (div),
        .div_signed (div_signed),
        .x          (x),
        .y          (y),
        .s          (s),
        .r          (r),
        .complete   (complete)
    );

    // Behavioural divider: LAT cycles of div high, one-cycle complete, then waits for div low.
    int cnt;
    bit done;
    always @(posedge clk) begin
        if (reset || !div) begin
            cnt      <= 0;
            done     <= 1'b0;
            complete <= 1'b0;
        end else if (complete) begin
            complete <= 1'b0;
            done     <= 1'b1;
        end else if (!done) begin
            if (cnt == LAT - 1) complete <= 1'b1;
            else cnt <= cnt + 1;
        end
    end

    always_comb begin
        s = '0;
        r = '0;
        if (complete) begin
            if (y == 32'd0) begin
                s = '1;
                r = x;
            end else if (div_signed) begin
                s = 32'($signed(x) / $signed(y));
                r = 32'($signed(x) % $signed(y));
            end else begin
                s = x / y;
                r = x % y;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        req_valid  = 1'b1;
        req_signed = sgn;
        req_x      = a;
        req_y      = b;
    endtask

    task automatic wait_complete(input string tag);
        int n = 0;
        while (complete !== 1'b1 && n < 64) begin
            step();
            n++;
        end
        chk(tag, 32'(complete), 32'd1);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_signed = 1'b0; req_x = '0; req_y = '0;
        flush = 1'b0; mt_hi_we = 1'b0; mt_lo_we = 1'b0; mt_wdata = '0; mf_req = 1'b0;
        repeat (3) step();
        chk("rst_div", 32'(div), 32'd0);
        chk("rst_sgn", 32'(div_signed), 32'd0);
        chk("rst_x", x, 32'd0);
        chk("rst_y", y, 32'd0);
        chk("rst_hi", hi_rdata, 32'd0);
        chk("rst_lo", lo_rdata, 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_stall", 32'(stall), 32'd0);
        reset = 1'b0;
        step();

        // 1: DIVU 100/7
        issue(1'b0, 32'd100, 32'd7);
        step();
        req_valid = 1'b0;
        chk("t1_div", 32'(div), 32'd1);
        chk("t1_ready", 32'(req_ready), 32'd0);
        chk("t1_x", x, 32'd100);
        wait_complete("t1_done");
        step();
        chk("t1_lo", lo_rdata, 32'd14);
        chk("t1_hi", hi_rdata, 32'd2);
        chk("t1_div_off", 32'(div), 32'd0);
        chk("t1_idle", 32'(req_ready), 32'd1);

        // 2: DIV -7/2, operands held through complete
        issue(1'b1, 32'hFFFF_FFF9, 32'd2);
        step();
        req_valid = 1'b0;
        wait_complete("t2_done");
        chk("t2_x_hold", x, 32'hFFFF_FFF9);
        chk("t2_y_hold", y, 32'd2);
        chk("t2_sgn_hold", 32'(div_signed), 32'd1);
        chk("t2_div_hold", 32'(div), 32'd1);
        step();
        chk("t2_lo", lo_rdata, 32'hFFFF_FFFD);
        chk("t2_hi", hi_rdata, 32'hFFFF_FFFF);

        // 3: flush 5 cycles into RUN, then DIVU 9/3
        issue(1'b0, 32'd50, 32'd5);
        step();
        req_valid = 1'b0;
        repeat (4) step();
        chk("t3_no_early", 32'(complete), 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t3_div_off", 32'(div), 32'd0);
        chk("t3_ready", 32'(req_ready), 32'd1);
        chk("t3_hi_keep", hi_rdata, 32'hFFFF_FFFF);
        chk("t3_lo_keep", lo_rdata, 32'hFFFF_FFFD);
        issue(1'b0, 32'd9, 32'd3);
        step();
        req_valid = 1'b0;
        wait_complete("t3_done");
        step();
        chk("t3_lo", lo_rdata, 32'd3);
        chk("t3_hi", hi_rdata, 32'd0);

        // 4: MF/MT during RUN stall; MTHI/MTLO while idle
        issue(1'b0, 32'd20, 32'd6);
        step();
        req_valid = 1'b0;
        mf_req = 1'b1;
        #1 chk("t4_stall_mf", 32'(stall), 32'd1);
        mf_req = 1'b0; mt_hi_we = 1'b1; mt_wdata = 32'hA5A5_A5A5;
        #1 chk("t4_stall_mt", 32'(stall), 32'd1);
        step();
        chk("t4_hi_blocked", hi_rdata, 32'd0);
        mt_hi_we = 1'b0;
        #1 chk("t4_no_stall", 32'(stall), 32'd0);
        wait_complete("t4_done");
        step();
        chk("t4_hi", hi_rdata, 32'd2);
        chk("t4_lo", lo_rdata, 32'd3);
        mt_hi_we = 1'b1; mt_wdata = 32'hA5A5_A5A5;
        #1 chk("t4_idle_stall", 32'(stall), 32'd0);
        step();
        mt_hi_we = 1'b0;
        chk("t4_mthi", hi_rdata, 32'hA5A5_A5A5);
        chk("t4_lo_keep", lo_rdata, 32'd3);
        mt_lo_we = 1'b1; mt_wdata = 32'h0000_005A;
        step();
        mt_lo_we = 1'b0;
        chk("t4_mtlo", lo_rdata, 32'h0000_005A);
        chk("t4_hi_keep", hi_rdata, 32'hA5A5_A5A5);

        // 5: back-to-back, second request held through the first
        issue(1'b0, 32'd100, 32'd7);
        step();
        req_x = 32'd45; req_y = 32'd4;
        #1 chk("t5_stall_req", 32'(stall), 32'd1);
        wait_complete("t5_done1");
        step();
        chk("t5_gap_div", 32'(div), 32'd0);
        chk("t5_gap_ready", 32'(req_ready), 32'd1);
        chk("t5_lo1", lo_rdata, 32'd14);
        chk("t5_hi1", hi_rdata, 32'd2);
        step();
        req_valid = 1'b0;
        chk("t5_div2", 32'(div), 32'd1);
        chk("t5_x2", x, 32'd45);
        wait_complete("t5_done2");
        step();
        chk("t5_lo2", lo_rdata, 32'd11);
        chk("t5_hi2", hi_rdata, 32'd1);

        // 6: divide by zero
        issue(1'b0, 32'h0000_1234, 32'd0);
        step();
        req_valid = 1'b0;
`ifdef DIV_ZERO_FAST_EN
        chk("t6_div_off", 32'(div), 32'd0);
        chk("t6_ready", 32'(req_ready), 32'd1);
        chk("t6_lo", lo_rdata, 32'hFFFF_FFFF);
        chk("t6_hi", hi_rdata, 32'h0000_1234);
        step();
        chk("t6_div_still_off", 32'(div), 32'd0);
`else
        chk("t6_div_on", 32'(div), 32'd1);
        wait_complete("t6_done");
        step();
        chk("t6_div_off", 32'(div), 32'd0);
        chk("t6_lo", lo_rdata, 32'hFFFF_FFFF);
        chk("t6_hi", hi_rdata, 32'h0000_1234);
`endif

        // 7: request with flush in IDLE is dropped; reset mid-RUN
        issue(1'b0, 32'd8, 32'd2);
        flush = 1'b1;
        step();
        req_valid = 1'b0; flush = 1'b0;
        chk("t7_flush_drop", 32'(div), 32'd0);
        chk("t7_flush_ready", 32'(req_ready), 32'd1);
        issue(1'b1, 32'd8, 32'd2);
        step();
        req_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t7_rst_div", 32'(div), 32'd0);
        chk("t7_rst_ready", 32'(req_ready), 32'd1);
        chk("t7_rst_hi", hi_rdata, 32'd0);
        chk("t7_rst_lo", lo_rdata, 32'd0);
        chk("t7_rst_sgn", 32'(div_signed), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
